dualport_mem_arbiter: RTL and testbench

//  Single-clock arbiter that shares the write and read ports of a dualport_mem among
//  NUM_REQ requesters. Two independent round-robin arbiters (write, read) drive a

---
 rtl/dualport_mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_dualport_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dualport_mem_arbiter.sv
// ---------------------------------------------------------------------------
// dualport_mem_arbiter
//   Shares the write port and the read port of one single-clock dual-port
//   memory among NUM_REQ requesters. Independent round-robin arbiters pick
//   one writer and one reader per cycle. The winners are registered into the
//   memory command stage. Read data comes back two cycles after the grant,
//   tagged with the id of the requester that issued it.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_req/wr_addr/wr_data     per-requester write requests (packed, i at [i*W +: W])
//   wr_gnt                     one-hot write grant (combinational)
//   rd_req/rd_addr             per-requester read requests (packed)
//   rd_gnt                     one-hot read grant (combinational)
//   rd_valid/rd_id/rd_data     read response
//   mem_w_*                    registered write command to the memory
//   mem_r_en/mem_r_addr        registered read command to the memory
//   mem_r_data                 registered read data from the memory
//
// Configuration
//   WR_BYPASS_EN  when defined, a same-cycle write/read to the same memory
//                 address returns the new write data instead of the old data.
// ---------------------------------------------------------------------------
module dualport_mem_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            wr_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]            wr_gnt,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_REQ-1:0]            rd_gnt,
  output logic                          rd_valid,
  output logic [ID_W-1:0]               rd_id,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          mem_w_en,
  output logic [ADDR_WIDTH-1:0]         mem_w_addr,
  output logic [DATA_WIDTH-1:0]         mem_w_data,
  output logic                          mem_r_en,
  output logic [ADDR_WIDTH-1:0]         mem_r_addr,
  input  logic [DATA_WIDTH-1:0]         mem_r_data
);

  // First requesting index found searching ptr, ptr+1, ... modulo NUM_REQ.
  function automatic logic [NUM_REQ-1:0] rr_grant(input logic [NUM_REQ-1:0] req,
                                                  input logic [ID_W-1:0]    ptr);
    logic [NUM_REQ-1:0] gnt;
    logic               found;
    int                 idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  function automatic logic [ID_W-1:0] onehot_to_id(input logic [NUM_REQ-1:0] oh);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) id = ID_W'(i);
    end
    return id;
  endfunction

  // Pointer moves just past the winner; explicit wrap keeps non-power-of-2
  // NUM_REQ inside 0..NUM_REQ-1.
  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  logic [ID_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ID_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic                  mem_w_en_q, mem_w_en_d;
  logic [ADDR_WIDTH-1:0] mem_w_addr_q, mem_w_addr_d;
  logic [DATA_WIDTH-1:0] mem_w_data_q, mem_w_data_d;
  logic                  mem_r_en_q, mem_r_en_d;
  logic [ADDR_WIDTH-1:0] mem_r_addr_q, mem_r_addr_d;
  logic [ID_W-1:0]       rd_id_s1_q, rd_id_s1_d;   // id of the read in the memory stage
  logic                  rd_valid_q, rd_valid_d;
  logic [ID_W-1:0]       rd_id_q, rd_id_d;
  logic [ID_W-1:0]       wr_win, rd_win;

  // Grants are forced low while reset is asserted so no transfer is ever
  // observed by a requester during reset.
  always_comb begin
    wr_gnt = rst_n ? rr_grant(wr_req, wr_ptr_q) : '0;
    rd_gnt = rst_n ? rr_grant(rd_req, rd_ptr_q) : '0;
    wr_win = onehot_to_id(wr_gnt);
    rd_win = onehot_to_id(rd_gnt);
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    wr_ptr_d     = wr_ptr_q;
    mem_w_en_d   = |wr_gnt;
    mem_w_addr_d = mem_w_addr_q;
    mem_w_data_d = mem_w_data_q;
    rd_ptr_d     = rd_ptr_q;
    mem_r_en_d   = |rd_gnt;
    mem_r_addr_d = mem_r_addr_q;
    rd_id_s1_d   = rd_id_s1_q;
    rd_valid_d   = mem_r_en_q;
    rd_id_d      = rd_id_s1_q;
    if (|wr_gnt) begin
      wr_ptr_d     = ptr_after(wr_win);
      mem_w_addr_d = wr_addr[wr_win*ADDR_WIDTH +: ADDR_WIDTH];
      mem_w_data_d = wr_data[wr_win*DATA_WIDTH +: DATA_WIDTH];
    end
    if (|rd_gnt) begin
      rd_ptr_d     = ptr_after(rd_win);
      mem_r_addr_d = rd_addr[rd_win*ADDR_WIDTH +: ADDR_WIDTH];
      rd_id_s1_d   = rd_win;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_w_en_q   <= 1'b0;
      mem_w_addr_q <= '0;
      mem_w_data_q <= '0;
      mem_r_en_q   <= 1'b0;
      mem_r_addr_q <= '0;
      rd_id_s1_q   <= '0;
      rd_valid_q   <= 1'b0;
      rd_id_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_w_en_q   <= mem_w_en_d;
      mem_w_addr_q <= mem_w_addr_d;
      mem_w_data_q <= mem_w_data_d;
      mem_r_en_q   <= mem_r_en_d;
      mem_r_addr_q <= mem_r_addr_d;
      rd_id_s1_q   <= rd_id_s1_d;
      rd_valid_q   <= rd_valid_d;
      rd_id_q      <= rd_id_d;
    end
  end

  assign mem_w_en   = mem_w_en_q;
  assign mem_w_addr = mem_w_addr_q;
  assign mem_w_data = mem_w_data_q;
  assign mem_r_en   = mem_r_en_q;
  assign mem_r_addr = mem_r_addr_q;
  assign rd_valid   = rd_valid_q;
  assign rd_id      = rd_id_q;

`ifdef WR_BYPASS_EN
  // A write and a read hitting the same address in the memory stage: the
  // memory returns the old word, so remember the new word and substitute it
  // when that read's data appears in the next cycle.
  logic                  byp_hit_q, byp_hit_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

  always_comb begin
    byp_hit_d  = mem_w_en_q & mem_r_en_q & (mem_w_addr_q == mem_r_addr_q);
    byp_data_d = byp_hit_d ? mem_w_data_q : byp_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q  <= byp_hit_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign rd_data = byp_hit_q ? byp_data_q : mem_r_data;
`else
  assign rd_data = mem_r_data;
`endif

endmodule

// File: tb/tb_dualport_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dualport_mem_arbiter
//   Bench for dualport_mem_arbiter with a behavioural dual-port memory
//   attached. A reference model tracks round-robin pointers, the memory
//   contents and a queue of expected read responses. Directed scenarios are
//   followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_dualport_mem_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;
  localparam int ID_W       = 2;
  localparam int DEPTH      = 16;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic [NUM_REQ-1:0]            wr_req = '0, rd_req = '0;
  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr = '0, rd_addr = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data = '0;
  logic [NUM_REQ-1:0]            wr_gnt, rd_gnt;
  logic                          rd_valid;
  logic [ID_W-1:0]               rd_id;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          mem_w_en, mem_r_en;
  logic [ADDR_WIDTH-1:0]         mem_w_addr, mem_r_addr;
  logic [DATA_WIDTH-1:0]         mem_w_data, mem_r_data;

  always #5 clk = ~clk;

  dualport_mem_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
  );

  // Behavioural dual-port memory: registered read, old data on collision.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_WIDTH'(i * 37 + 11);
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= mem[mem_r_addr];
  end

  // ---------------- reference model ----------------
  typedef struct {
    int                    due;
    int                    id;
    logic [DATA_WIDTH-1:0] data;
  } resp_t;

  resp_t                 exp_q[$];
  logic [DATA_WIDTH-1:0] ref_mem [DEPTH];
  int                    m_wr_ptr, m_rd_ptr, cyc;
  logic                  exp_w_en, exp_r_en;
  logic [ADDR_WIDTH-1:0] exp_w_addr, exp_r_addr;
  logic [DATA_WIDTH-1:0] exp_w_data;

  logic [ADDR_WIDTH-1:0] wa [NUM_REQ];
  logic [DATA_WIDTH-1:0] wd [NUM_REQ];
  logic [ADDR_WIDTH-1:0] ra [NUM_REQ];

  logic                  obs_valid;
  logic [ID_W-1:0]       obs_id;
  logic [DATA_WIDTH-1:0] obs_data;
  logic [NUM_REQ-1:0]    obs_wgnt, obs_rgnt;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Round-robin rule: first requester at ptr, ptr+1, ... modulo NUM_REQ; -1 if none.
  function automatic int rr(input logic [NUM_REQ-1:0] req, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (req[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  // One clock cycle: check registered outputs, apply requests, check grants,
  // then advance the model as if the granted transfers happen at the next edge.
  task automatic step(input logic [NUM_REQ-1:0] wreq, input logic [NUM_REQ-1:0] rreq);
    int wi, ri;
    logic [DATA_WIDTH-1:0] rdv;
    @(negedge clk);
    cyc++;
    check("mem_w_en", mem_w_en, exp_w_en);
    if (exp_w_en) begin
      check("mem_w_addr", mem_w_addr, exp_w_addr);
      check("mem_w_data", mem_w_data, exp_w_data);
    end
    check("mem_r_en", mem_r_en, exp_r_en);
    if (exp_r_en) check("mem_r_addr", mem_r_addr, exp_r_addr);
    obs_valid = rd_valid;
    obs_id    = rd_id;
    obs_data  = rd_data;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("rd_valid", rd_valid, 1);
      check("rd_id", rd_id, exp_q[0].id);
      check("rd_data", rd_data, exp_q[0].data);
      void'(exp_q.pop_front());
    end else begin
      check("rd_valid_idle", rd_valid, 0);
    end

    wr_req = wreq;
    rd_req = rreq;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = wa[i];
      wr_data[i*DATA_WIDTH +: DATA_WIDTH] = wd[i];
      rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = ra[i];
    end
    #1;
    wi = rr(wreq, m_wr_ptr);
    ri = rr(rreq, m_rd_ptr);
    check("wr_gnt", wr_gnt, (wi < 0) ? 0 : (1 << wi));
    check("rd_gnt", rd_gnt, (ri < 0) ? 0 : (1 << ri));
    obs_wgnt = wr_gnt;
    obs_rgnt = rd_gnt;

    exp_w_en = (wi >= 0);
    exp_r_en = (ri >= 0);
    if (wi >= 0) begin
      exp_w_addr = wa[wi];
      exp_w_data = wd[wi];
      m_wr_ptr   = (wi + 1) % NUM_REQ;
    end
    if (ri >= 0) begin
      exp_r_addr = ra[ri];
      m_rd_ptr   = (ri + 1) % NUM_REQ;
      // A read sees every write granted in earlier cycles; a write granted in
      // the same cycle reaches the array together with the read (old data).
      rdv = ref_mem[ra[ri]];
`ifdef WR_BYPASS_EN
      if (wi >= 0 && wa[wi] == ra[ri]) rdv = wd[wi];
`endif
      exp_q.push_back('{due: cyc + 2, id: ri, data: rdv});
    end
    if (wi >= 0) ref_mem[wa[wi]] = wd[wi];
  endtask

  task automatic do_reset(input int cycles);
    rst_n  = 1'b0;
    wr_req = '1;
    rd_req = '1;
    #1;
    check("rst_wr_gnt", wr_gnt, 0);
    check("rst_rd_gnt", rd_gnt, 0);
    check("rst_mem_w_en", mem_w_en, 0);
    check("rst_mem_r_en", mem_r_en, 0);
    check("rst_mem_w_addr", mem_w_addr, 0);
    check("rst_mem_w_data", mem_w_data, 0);
    check("rst_mem_r_addr", mem_r_addr, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_id", rd_id, 0);
    repeat (cycles) begin
      @(negedge clk);
      check("rst_hold_rd_valid", rd_valid, 0);
      check("rst_hold_wr_gnt", wr_gnt, 0);
    end
    m_wr_ptr = 0;
    m_rd_ptr = 0;
    exp_q.delete();
    exp_w_en = 1'b0;
    exp_r_en = 1'b0;
    wr_req   = '0;
    rd_req   = '0;
    rst_n    = 1'b1;
  endtask

  initial begin
    logic [NUM_REQ-1:0] wreq, rreq;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DATA_WIDTH'(i * 37 + 11);
    for (int i = 0; i < NUM_REQ; i++) begin
      wa[i] = '0; wd[i] = '0; ra[i] = '0;
    end
    cyc = 0;
    do_reset(3);

    // Round-robin over all four, then over requesters 1 and 3.
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 4'b0000);
      check("rr_all", obs_wgnt, 1 << (k % 4));
    end
    for (int k = 0; k < 3; k++) begin
      step(4'b1010, 4'b0000);
      check("rr_1010", obs_wgnt, (k == 1) ? 4'b1000 : 4'b0010);
    end

    // Write then read back by another requester.
    wa[0] = 4'd3; wd[0] = 8'hA5;
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    ra[2] = 4'd3;
    step(4'b0000, 4'b0100);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    check("wr_rd_valid", obs_valid, 1);
    check("wr_rd_id", obs_id, 2);
    check("wr_rd_data", obs_data, 8'hA5);

    // Same-cycle write and read to one address.
    wa[0] = 4'd5; wd[0] = 8'h11;
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    wa[0] = 4'd5; wd[0] = 8'h3C; ra[1] = 4'd5;
    step(4'b0001, 4'b0010);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    check("coll_valid", obs_valid, 1);
`ifdef WR_BYPASS_EN
    check("coll_data", obs_data, 8'h3C);
`else
    check("coll_data", obs_data, 8'h11);
`endif

    // Reset one cycle after a read grant: that read must never respond.
    ra[1] = 4'd7;
    step(4'b0000, 4'b0010);
    @(negedge clk);
    check("mid_r_en", mem_r_en, 1);
    do_reset(2);

    // Streaming reads; first grants also show both pointers back at 0.
    for (int i = 0; i < NUM_REQ; i++) ra[i] = ADDR_WIDTH'(i + 8);
    wd[0] = 8'h5A;
    for (int k = 0; k < 18; k++) begin
      step((k == 0) ? 4'b1111 : 4'b0000, (k < 16) ? 4'b1111 : 4'b0000);
      if (k == 0) begin
        check("post_rst_wr_gnt", obs_wgnt, 4'b0001);
        check("post_rst_rd_gnt", obs_rgnt, 4'b0001);
      end
      if (k < 2) check("stream_pre", obs_valid, 0);
      else begin
        check("stream_valid", obs_valid, 1);
        check("stream_id", obs_id, (k - 2) % 4);
      end
    end

    // Randomized traffic; a requester holds its request until granted.
    wreq = '0;
    rreq = '0;
    obs_wgnt = '0;
    obs_rgnt = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!(wreq[i] && !obs_wgnt[i])) begin
          wreq[i] = ($urandom_range(0, 3) != 0);
          wa[i]   = ADDR_WIDTH'($urandom_range(0, 5));
          wd[i]   = DATA_WIDTH'($urandom);
        end
        if (!(rreq[i] && !obs_rgnt[i])) begin
          rreq[i] = ($urandom_range(0, 2) != 0);
          ra[i]   = ADDR_WIDTH'($urandom_range(0, 5));
        end
      end
      step(wreq, rreq);
    end
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
